// File: rtl/snn_step_seq.sv
// Timestep sequencer for snn_core: fetch events, settle, emit spike rows, optional STDP scan.
// Optional weight dump stream is compiled in with `define SNN_SEQ_WDUMP_EN.
module snn_step_seq #(
  parameter int unsigned F  = 48,
  parameter int unsigned N  = 96,
  parameter int unsigned TW = 16,
  parameter int unsigned AW = $clog2(F*N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [TW-1:0] t_steps,
  input  logic          learn_en,
  output logic          busy,
  output logic          done,
  output logic          ev_rd,
  output logic [TW-1:0] ev_addr,
  input  logic [F-1:0]  ev_data,
  output logic [F-1:0]  core_event_vec,
  input  logic [N-1:0]  core_spikes,
  output logic          stdp_enable,
  output logic [F-1:0]  stdp_pre_bits,
  output logic [N-1:0]  stdp_post_bits,
  output logic          spk_valid,
  output logic [N-1:0]  spk_data,
  output logic [TW-1:0] spk_step,
  input  logic          spk_ready,
  output logic [AW-1:0] rb_addr,
  input  logic [15:0]   rb_data,
  output logic          wb_valid,
  output logic [AW-1:0] wb_addr,
  output logic [15:0]   wb_data,
  input  logic          wb_ready
);

  localparam logic [AW:0] LAST_IDX = (AW+1)'(F*N-1);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_LOAD, S_SETTLE, S_EMIT, S_LEARN, S_GAP, S_NEXT,
`ifdef SNN_SEQ_WDUMP_EN
    S_DUMP_ADDR, S_DUMP_WAIT, S_DUMP_OUT,
`endif
    S_DONE
  } state_t;

  state_t        state, nxt;
  logic [TW-1:0] t_q;
  logic [TW-1:0] steps_q;
  logic          learn_q;
  logic [AW:0]   cnt;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:   if (start) nxt = (t_steps == '0) ? S_DONE : S_FETCH;
      S_FETCH:  nxt = S_LOAD;
      S_LOAD:   nxt = S_SETTLE;
      S_SETTLE: nxt = S_EMIT;
      S_EMIT:   if (spk_ready) nxt = learn_q ? S_LEARN : S_NEXT;
      S_LEARN:  if (cnt == LAST_IDX) nxt = S_GAP;
      S_GAP:    nxt = S_NEXT;
      S_NEXT: begin
        if (t_q + TW'(1) == steps_q) begin
`ifdef SNN_SEQ_WDUMP_EN
          nxt = learn_q ? S_DUMP_ADDR : S_DONE;
`else
          nxt = S_DONE;
`endif
        end else begin
          nxt = S_FETCH;
        end
      end
`ifdef SNN_SEQ_WDUMP_EN
      S_DUMP_ADDR: nxt = S_DUMP_WAIT;
      S_DUMP_WAIT: nxt = S_DUMP_OUT;
      S_DUMP_OUT:  if (wb_ready) nxt = (cnt == LAST_IDX) ? S_DONE : S_DUMP_ADDR;
`endif
      S_DONE:   nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy           = (state != S_IDLE);
    done           = 1'b0;
    ev_rd          = 1'b0;
    ev_addr        = '0;
    spk_valid      = 1'b0;
    stdp_enable    = 1'b0;
    stdp_pre_bits  = '0;
    stdp_post_bits = '0;
    rb_addr        = '0;
    wb_valid       = 1'b0;
    case (state)
      S_FETCH: begin
        ev_rd   = 1'b1;
        ev_addr = t_q;
      end
      S_EMIT:  spk_valid = 1'b1;
      S_LEARN: begin
        stdp_enable    = 1'b1;
        stdp_pre_bits  = core_event_vec;
        stdp_post_bits = spk_data;
      end
`ifdef SNN_SEQ_WDUMP_EN
      S_DUMP_ADDR: rb_addr  = cnt[AW-1:0];
      S_DUMP_OUT:  wb_valid = 1'b1;
`endif
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // cnt doubles as the STDP scan counter and the dump word index
  always_ff @(posedge clk) begin
    if (rst) begin
      t_q            <= '0;
      steps_q        <= '0;
      learn_q        <= 1'b0;
      cnt            <= '0;
      core_event_vec <= '0;
      spk_data       <= '0;
      spk_step       <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          steps_q <= t_steps;
          learn_q <= learn_en;
          t_q     <= '0;
        end
        S_LOAD:   core_event_vec <= ev_data;
        S_SETTLE: begin
          spk_data <= core_spikes;
          spk_step <= t_q;
        end
        S_EMIT:   cnt <= '0;
        S_LEARN:  cnt <= cnt + (AW+1)'(1);
        S_NEXT: begin
          t_q <= t_q + TW'(1);
          cnt <= '0;
        end
`ifdef SNN_SEQ_WDUMP_EN
        S_DUMP_OUT: if (wb_ready) cnt <= cnt + (AW+1)'(1);
`endif
        default: ;
      endcase
      if (nxt == S_DONE) core_event_vec <= '0;
    end
  end

`ifdef SNN_SEQ_WDUMP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_addr <= '0;
      wb_data <= '0;
    end else if (state == S_DUMP_WAIT) begin
      wb_data <= rb_data;
      wb_addr <= cnt[AW-1:0];
    end
  end
`else
  assign wb_addr = '0;
  assign wb_data = '0;
  logic unused_dump;
  assign unused_dump = ^{rb_data, wb_ready};
`endif

endmodule

// File: doc/snn_step_seq.md
# snn_step_seq

Timestep sequencer for `snn_core`. It fetches one event vector per step from event memory, drives it into the core, and captures the spike vector. It streams spike rows out over a ready/valid port and, when learning is on, runs one full F×N STDP scan per step. It replaces testbench-driven stepping, so software starts a run with `start` and waits for `done`.

## Interface
- `F`, 48, input features (event vector width)
- `N`, 96, neurons (spike vector width)
- `TW`, 16, step counter / event-address width
- `AW`, `$clog2(F*N)`, weight readback address width

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  one-cycle run request; ignored while `busy`
- `t_steps`  in  TW  number of steps; latched on accepted `start`
- `learn_en`  in  1  enable STDP scans; latched on accepted `start`
- `busy`  out  1  high from accepted `start` until `done`
- `done`  out  1  one-cycle pulse when the run completes
- `ev_rd`  out  1  event memory read strobe
- `ev_addr`  out  TW  event memory address (= step index)
- `ev_data`  in  F  event word; valid exactly 1 cycle after `ev_rd`
- `core_event_vec`  out  F  registered event vector to `snn_core.event_vec`
- `core_spikes`  in  N  `snn_core.spikes_vec`
- `stdp_enable`  out  1  to core
- `stdp_pre_bits`  out  F  to core
- `stdp_post_bits`  out  N  to core
- `spk_valid`  out  1  spike row valid
- `spk_data`  out  N  spike row
- `spk_step`  out  TW  step index of the row
- `spk_ready`  in  1  sink accepts the row
- `rb_addr`  out  AW  core weight readback address
- `rb_data`  in  16  core readback data, valid 1 cycle after `rb_addr`
- `wb_valid`  out  1  learned weight word valid
- `wb_addr`  out  AW  weight index
- `wb_data`  out  16  weight value (signed Q14, passed through unchanged)
- `wb_ready`  in  1  sink accepts the word

## Operation
- States: IDLE, FETCH, LOAD, SETTLE, EMIT, LEARN, GAP, NEXT, DUMP_ADDR, DUMP_WAIT, DUMP_OUT, DONE.
- IDLE, `start`=1:
  - `t_steps`=0 → DONE.
  - Otherwise latch `t_steps` and `learn_en`, set t=0 → FETCH.
- FETCH: `ev_rd`=1, `ev_addr`=t → LOAD.
- LOAD: `core_event_vec`←`ev_data` → SETTLE.
- SETTLE: one cycle for the core update. At its end, `spk_data`←`core_spikes` and `spk_step`←t → EMIT.
- EMIT: `spk_valid`=1. `spk_data` and `spk_step` are held stable until `spk_ready`.
  - On the handshake: → LEARN if `learn_en`, else → NEXT.
- LEARN:
  - `stdp_enable`=1 for exactly F*N cycles, counted by an internal AW+1-bit counter.
  - `stdp_pre_bits`=`core_event_vec` and `stdp_post_bits`=captured `spk_data`; both held constant for the whole scan.
  - → GAP.
- GAP: `stdp_enable`=0 for one cycle → NEXT.
- NEXT: t←t+1.
  - If t+1==`t_steps`, the run is complete:
    - → DUMP_ADDR if `learn_en` and the dump feature is compiled in.
    - Otherwise → DONE.
  - Otherwise → FETCH.
- Dump loop, i = 0..F*N−1:
  - DUMP_ADDR: `rb_addr`=i → DUMP_WAIT.
  - DUMP_WAIT: `wb_data`←`rb_data`, `wb_addr`←i → DUMP_OUT.
  - DUMP_OUT: `wb_valid`=1 until `wb_ready`; then → DUMP_ADDR with i+1, or → DONE after i=F*N−1.
- DONE: `done`=1 for one cycle, `busy`=0 from the next cycle → IDLE.
- `core_event_vec` is cleared to 0 on entry to DONE, so an idle core sees no events.
- `start` asserted while `busy` is dropped. It is not queued.
- No index wraps: t is at most 65535, and `ev_addr` ranges over 0..`t_steps`−1.

## Timing
- Reset values: all outputs 0; state IDLE.
- Reset mid-run: every output is 0 on the edge after `rst` is sampled, including `stdp_enable`. A partial scan or dump is abandoned and no `done` pulse is issued.
- `start` → `ev_rd` high on the following cycle. `busy` is high from that same cycle.
- Steady step with `spk_ready` held high:
  - Without learning: 5 cycles (FETCH, LOAD, SETTLE, EMIT, NEXT).
  - With learning: 6+F*N cycles (4608+6 = 4614 with default F=48, N=96).
- Each dump word takes 3 cycles with `wb_ready` high.
- Last `spk_valid` handshake (no learning) → `done` 2 cycles later.
- `stdp_enable` is never high outside LEARN. There is always at least one low cycle between scans.

## Configuration
- `SNN_SEQ_WDUMP_EN` defined:
  - Dump states, the `rb_addr` sequencing and the `wb_*` stream are compiled in.
  - The dump runs after the final step whenever `learn_en` was latched.
- Not defined:
  - Dump states are removed.
  - `rb_addr`, `wb_valid`, `wb_addr` and `wb_data` are tied to 0, and `wb_ready` is ignored.
  - NEXT goes directly to DONE.
  - The port list is unchanged.

## Test plan
- `t_steps`=3, `learn_en`=0, `spk_ready`=1, events {1,2,4}, core model spikes = event bit0 → 3 rows with `spk_step` 0,1,2; `done` at cycle 16 after `start`; `stdp_enable` never high.
- `t_steps`=2, `learn_en`=1 → `stdp_enable` high for exactly 4608 consecutive cycles per step; pre/post bits stable throughout and equal to the step's event and spike row.
- Random `spk_ready` low for 0–7 cycles → `spk_data` and `spk_step` do not change while `spk_valid` is high and `spk_ready` is low; no row is lost or duplicated.
- `t_steps`=0 → `done` 1 cycle after `start`; `ev_rd` never asserted. A second `start` while `busy` → ignored, and exactly one `done` pulse results.
- `rst` asserted in the middle of LEARN → `stdp_enable`=0 on the next cycle, state IDLE, no `done`; a new `start` runs normally.
- With `SNN_SEQ_WDUMP_EN`, `learn_en`=1 → 4608 `wb` words with addresses 0..4607 in order, `wb_data` equal to the core readback at each address. Without the macro, `wb_valid` stays 0.
